// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
// Holds the fetch FSM state encoding, the IF/ID update operations, the
// bubble (NOP) encoding that decode also injects, and the default reset
// and interrupt vector addresses.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        BOOT_HI = 3'd0,
        BOOT_LO = 3'd1,
        RUN     = 3'd2,
        VEC_HI  = 3'd3,
        VEC_LO  = 3'd4
    } fetch_state_t;

    // Update applied to the IF/ID register on a clock edge
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_IMM    = 2'd2,
        IFID_LOAD   = 2'd3
    } ifid_op_t;

    localparam logic [15:0] NOP_ENC           = 16'h4000;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'd0;
    localparam logic [31:0] INT_VEC_DEFAULT   = 32'd2;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   op              update for this edge (hold, bubble, immediate capture, load)
//   instr_in        fetched word (instruction or LDM immediate)
//   pc_in           PC+1 of the fetched word
//   ifid_valid/instr/pc/imm  registered IF/ID contents
module ifid_reg
    import fetch_unit_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter logic [15:0] NOP_WORD = NOP_ENC
) (
    input  logic            clk,
    input  logic            reset,
    input  ifid_op_t        op,
    input  logic [15:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            ifid_valid,
    output logic [15:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic [15:0]     ifid_imm
);

    logic            valid_r,  valid_next_s;
    logic [15:0]     instr_r,  instr_next_s;
    logic [PC_W-1:0] pc_r,     pc_next_s;
    logic [15:0]     imm_r,    imm_next_s;

    // Next-value selection for every IF/ID field
    always_comb begin
        valid_next_s = valid_r;
        instr_next_s = instr_r;
        pc_next_s    = pc_r;
        imm_next_s   = imm_r;
        case (op)
            IFID_HOLD: begin
                valid_next_s = valid_r;
            end
            IFID_BUBBLE: begin
                valid_next_s = 1'b0;
                instr_next_s = NOP_WORD;
            end
            // LDM immediate: capture the word, present a bubble to decode
            IFID_IMM: begin
                valid_next_s = 1'b0;
                instr_next_s = NOP_WORD;
                imm_next_s   = instr_in;
            end
            IFID_LOAD: begin
                valid_next_s = 1'b1;
                instr_next_s = instr_in;
                pc_next_s    = pc_in;
            end
            default: begin
                valid_next_s = 1'b0;
                instr_next_s = NOP_WORD;
            end
        endcase
    end

    // IF/ID state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            instr_r <= NOP_WORD;
            pc_r    <= {PC_W{1'b0}};
            imm_r   <= 16'h0000;
        end else begin
            valid_r <= valid_next_s;
            instr_r <= instr_next_s;
            pc_r    <= pc_next_s;
            imm_r   <= imm_next_s;
        end
    end

    assign ifid_valid = valid_r;
    assign ifid_instr = instr_r;
    assign ifid_pc    = pc_r;
    assign ifid_imm   = imm_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, loads it from the reset/interrupt
// vectors with a two-word (high, then low) read, applies redirects and
// fills the IF/ID register.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   imem_addr/imem_rdata  instruction memory (combinational read)
//   stall                 hold PC and IF/ID
//   clear_instruction     current word is an LDM immediate
//   jump_valid/target     execute-stage redirect
//   mem_pc_valid/mem_pc   RET/RETI popped PC
//   int_vec_load          load interrupt vector
//   busy                  vector load in progress
//   ifid_*                IF/ID register contents
// The PC is assumed wider than 16 bits (two 16-bit vector halves).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter logic [PC_W-1:0] INT_VEC   = INT_VEC_DEFAULT,
    parameter logic [15:0]     NOP_WORD  = NOP_ENC
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            stall,
    input  logic            clear_instruction,
    input  logic            jump_valid,
    input  logic [PC_W-1:0] jump_target,
    input  logic            mem_pc_valid,
    input  logic [PC_W-1:0] mem_pc,
    input  logic            int_vec_load,
    output logic            busy,
    output logic            ifid_valid,
    output logic [15:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic [15:0]     ifid_imm
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    state_r, state_next_s;
    logic [PC_W-1:0] pc_r, pc_next_s, pc_inc_s;
    logic [PC_W-1:0] addr_r, addr_next_s;
    logic            busy_r;
    ifid_op_t        ifid_op_s;

    // Wraps modulo 2^PC_W naturally
    assign pc_inc_s = pc_r + PC_ONE;

    // Next state, next PC and IF/ID operation
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        ifid_op_s    = IFID_HOLD;
        case (state_r)
            BOOT_HI, VEC_HI: begin
                pc_next_s[PC_W-1:16] = imem_rdata[PC_W-17:0];
                ifid_op_s            = IFID_BUBBLE;
                state_next_s         = (state_r == BOOT_HI) ? BOOT_LO : VEC_LO;
            end
            BOOT_LO, VEC_LO: begin
                pc_next_s[15:0] = imem_rdata;
                ifid_op_s       = IFID_BUBBLE;
                state_next_s    = RUN;
            end
            RUN: begin
                if (int_vec_load) begin
                    state_next_s = VEC_HI;
                    ifid_op_s    = IFID_BUBBLE;
                end else if (mem_pc_valid) begin
                    pc_next_s = mem_pc;
                    ifid_op_s = IFID_BUBBLE;
                end else if (jump_valid) begin
                    // Bubble discards the wrong-path word fetched this cycle
                    pc_next_s = jump_target;
                    ifid_op_s = IFID_BUBBLE;
                end else if (stall) begin
                    ifid_op_s = IFID_HOLD;
                end else if (clear_instruction) begin
                    pc_next_s = pc_inc_s;
                    ifid_op_s = IFID_IMM;
                end else begin
                    pc_next_s = pc_inc_s;
                    ifid_op_s = IFID_LOAD;
                end
            end
            default: begin
                state_next_s = BOOT_HI;
                ifid_op_s    = IFID_BUBBLE;
            end
        endcase
    end

    // Memory address for the next cycle, so imem_addr comes straight from a flop
    always_comb begin
        addr_next_s = RESET_VEC;
        case (state_next_s)
            BOOT_HI: addr_next_s = RESET_VEC;
            BOOT_LO: addr_next_s = RESET_VEC + PC_ONE;
            VEC_HI:  addr_next_s = INT_VEC;
            VEC_LO:  addr_next_s = INT_VEC + PC_ONE;
            RUN:     addr_next_s = pc_next_s;
            default: addr_next_s = RESET_VEC;
        endcase
    end

    // FSM state, PC, address and busy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= BOOT_HI;
            pc_r    <= RESET_VEC;
            addr_r  <= RESET_VEC;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            addr_r  <= addr_next_s;
            busy_r  <= (state_next_s != RUN);
        end
    end

    assign imem_addr = addr_r;
    assign busy      = busy_r;

    ifid_reg #(
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clk        (clk),
        .reset      (reset),
        .op         (ifid_op_s),
        .instr_in   (imem_rdata),
        .pc_in      (pc_inc_s),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_imm   (ifid_imm)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus runs a reference model of the
// fetch rules and queues the expected post-edge outputs; a monitor pops and
// compares one entry after every clock edge.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h4000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall = 1'b0, clear_instruction = 1'b0;
    logic        jump_valid = 1'b0, mem_pc_valid = 1'b0, int_vec_load = 1'b0;
    logic [31:0] jump_target = 32'd0, mem_pc = 32'd0;
    logic        busy, ifid_valid;
    logic [15:0] ifid_instr, ifid_imm;
    logic [31:0] ifid_pc;

    logic [15:0] mem [256];
    assign imem_rdata = mem[imem_addr[7:0]];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .stall             (stall),
        .clear_instruction (clear_instruction),
        .jump_valid        (jump_valid),
        .jump_target       (jump_target),
        .mem_pc_valid      (mem_pc_valid),
        .mem_pc            (mem_pc),
        .int_vec_load      (int_vec_load),
        .busy              (busy),
        .ifid_valid        (ifid_valid),
        .ifid_instr        (ifid_instr),
        .ifid_pc           (ifid_pc),
        .ifid_imm          (ifid_imm)
    );

    typedef struct {
        logic        busy;
        logic        valid;
        logic [15:0] instr;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: words of vector still to load, PC, IF/ID contents
    int          m_left;
    logic [31:0] m_base, m_pc, m_ipc;
    logic        m_valid;
    logic [15:0] m_instr, m_imm;

    function automatic logic [31:0] m_addr();
        if (m_left == 2) return m_base;
        if (m_left == 1) return m_base + 32'd1;
        return m_pc;
    endfunction

    task automatic model_reset();
        m_left = 2; m_base = 32'd0; m_pc = 32'd0;
        m_valid = 1'b0; m_instr = NOP; m_ipc = 32'd0; m_imm = 16'h0000;
    endtask

    task automatic model_step(input logic iv, input logic mv, input logic [31:0] mp,
                              input logic jv, input logic [31:0] jt,
                              input logic st, input logic cl);
        logic [15:0] word;
        logic        bubble;
        word   = mem[m_addr() & 32'h0000_00FF];
        bubble = 1'b0;
        if (m_left == 2) begin
            m_pc = {word, m_pc[15:0]}; m_left = 1; bubble = 1'b1;
        end else if (m_left == 1) begin
            m_pc = {m_pc[31:16], word}; m_left = 0; bubble = 1'b1;
        end else if (iv) begin
            m_left = 2; m_base = 32'd2; bubble = 1'b1;
        end else if (mv) begin
            m_pc = mp; bubble = 1'b1;
        end else if (jv) begin
            m_pc = jt; bubble = 1'b1;
        end else if (st) begin
            m_pc = m_pc;
        end else if (cl) begin
            m_imm = word; m_valid = 1'b0; m_instr = NOP; m_pc = m_pc + 32'd1;
        end else begin
            m_instr = word; m_ipc = m_pc + 32'd1; m_valid = 1'b1; m_pc = m_pc + 32'd1;
        end
        if (bubble) begin
            m_valid = 1'b0; m_instr = NOP;
        end
    endtask

    // Called at a falling edge: drive inputs, predict, then wait one cycle
    task automatic drive_cycle(input logic iv, input logic mv, input logic [31:0] mp,
                               input logic jv, input logic [31:0] jt,
                               input logic st, input logic cl);
        exp_t e;
        int_vec_load = iv; mem_pc_valid = mv; mem_pc = mp;
        jump_valid = jv; jump_target = jt; stall = st; clear_instruction = cl;
        model_step(iv, mv, mp, jv, jt, st, cl);
        e.busy = (m_left != 0); e.valid = m_valid; e.instr = m_instr;
        e.pc = m_ipc; e.imm = m_imm; e.addr = m_addr();
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset applied mid-cycle; returns at a falling edge with reset released
    task automatic reset_dut();
        reset = 1'b0;
        int_vec_load = 1'b0; mem_pc_valid = 1'b0; jump_valid = 1'b0;
        stall = 1'b0; clear_instruction = 1'b0;
        model_reset();
        #1;
        chk("rst_busy",  busy,       32'd1);
        chk("rst_valid", ifid_valid, 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc",    ifid_pc,    32'd0);
        chk("rst_imm",   ifid_imm,   32'd0);
        chk("rst_addr",  imem_addr,  32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_busy",  busy,       e.busy);
                chk("sb_valid", ifid_valid, e.valid);
                chk("sb_instr", ifid_instr, e.instr);
                chk("sb_pc",    ifid_pc,    e.pc);
                chk("sb_imm",   ifid_imm,   e.imm);
                chk("sb_addr",  imem_addr,  e.addr);
            end
        end
    end

    initial begin
        logic iv, mv, jv, st, cl;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom());
        mem[0] = 16'h0000; mem[1] = 16'h0010;
        mem[2] = 16'h0000; mem[3] = 16'h0080;
        mem[8'h10] = 16'hA5A5;
        mem[8'h11] = 16'h1234;

        @(negedge clk);
        reset_dut();

        // Boot: two vector reads, then first fetch from 0x10
        idle(2);
        chk("boot_addr", imem_addr, 32'h10);
        idle(1);
        chk("first_instr", ifid_instr, 16'hA5A5);
        chk("first_pc",    ifid_pc,    32'h11);

        // LDM immediate capture
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("ldm_imm",   ifid_imm,   16'h1234);
        chk("ldm_valid", ifid_valid, 32'd0);
        chk("ldm_instr", ifid_instr, NOP);
        chk("ldm_next",  imem_addr,  32'h12);

        // Stall held 3 cycles at pc 0x15
        idle(3);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("stall_addr", imem_addr, 32'h15);
        chk("stall_pc",   ifid_pc,   32'h15);

        // Jump beats stall; target instruction two edges after request
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1, 1'b0);
        chk("jump_bubble", ifid_valid, 32'd0);
        idle(1);
        chk("jump_pc", ifid_pc, 32'h41);

        // RET pop beats jump
        drive_cycle(1'b0, 1'b1, 32'h20, 1'b1, 32'h40, 1'b0, 1'b0);
        chk("ret_addr", imem_addr, 32'h20);
        idle(1);

        // Interrupt vector load, jumps during busy ignored
        drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("int_busy", busy, 32'd1);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h55, 1'b0, 1'b0);
        chk("int_addr", imem_addr, 32'h80);
        chk("int_done", busy,      32'd0);
        idle(1);
        chk("int_pc", ifid_pc, 32'h81);

        // PC wrap at the top of the address space
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(1);
        chk("wrap_pc",   ifid_pc,   32'd0);
        chk("wrap_addr", imem_addr, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            iv = (m_left == 0) ? ($urandom_range(99) < 4) : ($urandom_range(99) < 2);
            mv = ($urandom_range(99) < 6);
            jv = ($urandom_range(99) < 10);
            st = ($urandom_range(99) < 20);
            cl = ($urandom_range(99) < 10);
            drive_cycle(iv, mv, $urandom(), jv, $urandom(), st, cl);
        end

        // Reset during VEC_LO discards the partial PC
        for (int i = 0; i < 4 && m_left != 0; i++) idle(1);
        drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        idle(1);
        reset_dut();
        idle(3);
        chk("reboot_pc", ifid_pc, 32'h11);

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
